axi4_lite_master: RTL and testbench
===================================

AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master
Interface
REQ-001 SHALL have parameter ADDR_W, default 32: AXI address width; data width fixed at 32.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024: watchdog limit in clk cycles (used only when A4LM_TIMEOUT_EN is defined).
REQ-003 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port a4lm_addr  in  ADDR_W  target address from the TLP decoder.
REQ-006 SHALL have port a4lm_wr_data  in  32  write data from the TLP decoder.
REQ-007 SHALL have port a4lm_wr_cmd  in  1  one-cycle write request pulse.
REQ-008 SHALL have port a4lm_rd_cmd  in  1  one-cycle read request pulse.
REQ-009 SHALL have port a4lm_valid  out  1  one-cycle completion pulse to the TLP encoder.
REQ-010 SHALL have port a4lm_data  out  32  read data; 0 for writes and errors.
REQ-011 SHALL have port a4lm_err_code  out  3  {timeout, resp[1:0]}; 3'b000 = OKAY.
REQ-012 SHALL have port m_axi_awaddr  out  ADDR_W  write address.
REQ-013 SHALL have port m_axi_awvalid  out  1  write address valid.
REQ-014 SHALL have port m_axi_awready  in  1  write address ready.
REQ-015 SHALL have port m_axi_wdata  out  32  write data.
REQ-016 SHALL have port m_axi_wstrb  out  4  byte strobes, constant 4'hF.
REQ-017 SHALL have port m_axi_wvalid  out  1  write data valid.
REQ-018 SHALL have port m_axi_wready  in  1  write data ready.
REQ-019 SHALL have port m_axi_bresp  in  2  write response code.
REQ-020 SHALL have port m_axi_bvalid  in  1  write response valid.
REQ-021 SHALL have port m_axi_bready  out  1  write response ready.
REQ-022 SHALL have port m_axi_araddr  out  ADDR_W  read address.
REQ-023 SHALL have port m_axi_arvalid  out  1  read address valid.
REQ-024 SHALL have port m_axi_arready  in  1  read address ready.
REQ-025 SHALL have port m_axi_rdata  in  32  read data.
REQ-026 SHALL have port m_axi_rresp  in  2  read response code.
REQ-027 SHALL have port m_axi_rvalid  in  1  read data valid.
REQ-028 SHALL have port m_axi_rready  out  1  read data ready.
Function
REQ-029 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE; all outputs registered.
REQ-030 SHALL, in IDLE on a4lm_wr_cmd, latch addr/data, go to WR_REQ, assert awvalid and wvalid the next cycle (1-cycle latency).
REQ-031 SHALL, in WR_REQ, track AW and W handshakes independently: drop each valid on its own handshake (valid&ready); go to WR_RESP once both are done, including when both complete in the same cycle.
REQ-032 SHALL, in IDLE on a4lm_rd_cmd, latch addr, go to RD_REQ, assert arvalid the next cycle; drop it on handshake and go to RD_RESP.
REQ-033 SHALL, when wr_cmd and rd_cmd are both asserted in IDLE, take the write and drop the read.
REQ-034 SHALL ignore commands in any state other than IDLE.
REQ-035 SHALL keep bready high in WR_RESP and rready high in RD_RESP; on bvalid/rvalid, capture resp (and rdata when rresp==2'b00) and go to DONE.
REQ-036 SHALL, in DONE, pulse a4lm_valid for exactly one cycle with data/err_code stable, then return to IDLE; data and err_code SHALL hold until the next completion.
REQ-037 SHALL hold every valid, address and data stable until its handshake (AXI rule).
REQ-038 SHALL hold bready and rready high in IDLE, so stray responses are absorbed silently without producing a4lm_valid.
Reset
REQ-039 SHALL, on reset asserted (any time, including mid-transaction), asynchronously force IDLE and drive all outputs to 0 except m_axi_wstrb=4'hF, and clear the watchdog.
Configuration
REQ-040 SHALL, with A4LM_TIMEOUT_EN defined, count cycles in WR_REQ/WR_RESP/RD_REQ/RD_RESP; on reaching TIMEOUT_CYC, deassert all AXI valids, go to DONE with err_code 3'b100 and data 0.
REQ-041 SHALL, without A4LM_TIMEOUT_EN, contain no watchdog logic, wait indefinitely, and never set err_code[2].
Verification
REQ-042 SHALL cover: wr_cmd addr 0x10 data 0xA5A5A5A5, awready and wready same cycle, bresp 00 -> one a4lm_valid, err 000, AW/W values correct.
REQ-043 SHALL cover: wready 3 cycles before awready -> wvalid drops first, awvalid held, one bready handshake, err 000.
REQ-044 SHALL cover: rd_cmd addr 0x20, rdata 0xDEADBEEF, rresp 00 -> a4lm_data 0xDEADBEEF, err 000; rresp 10 -> data 0, err 010.
REQ-045 SHALL cover: wr_cmd and rd_cmd in the same cycle -> write only, no arvalid; extra rd_cmd while busy -> ignored.
REQ-046 SHALL cover: TIMEOUT_CYC=16, arready held low -> a4lm_valid 17 cycles after arvalid, err 100 (macro defined); stall forever (undefined).
REQ-047 SHALL cover: reset pulsed during WR_RESP -> all valids 0 immediately; next command completes normally.

Source files
------------

// File: rtl/axi4_lite_master.sv
// AXI4-Lite single-outstanding master bridging TLP decoder requests to AXI and back.
// Optional watchdog enabled by defining A4LM_TIMEOUT_EN.
module axi4_lite_master #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a4lm_addr,
  input  logic [31:0]       a4lm_wr_data,
  input  logic              a4lm_wr_cmd,
  input  logic              a4lm_rd_cmd,
  output logic              a4lm_valid,
  output logic [31:0]       a4lm_data,
  output logic [2:0]        a4lm_err_code,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [31:0]       wdata_r, wdata_s;
  logic              awvalid_r, awvalid_s;
  logic              wvalid_r, wvalid_s;
  logic              arvalid_r, arvalid_s;
  logic              bready_r, bready_s;
  logic              rready_r, rready_s;
  logic              valid_r, valid_s;
  logic [31:0]       data_r, data_s;
  logic [2:0]        err_r, err_s;
  logic              busy_s;
  logic              timeout_s;

  assign busy_s = (state_r == WR_REQ) || (state_r == WR_RESP) ||
                  (state_r == RD_REQ) || (state_r == RD_RESP);

`ifdef A4LM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wdog_r;

  // Watchdog counts only while a transaction is outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_r <= '0;
    end else if (busy_s) begin
      wdog_r <= wdog_r + CNT_W'(1);
    end else begin
      wdog_r <= '0;
    end
  end

  assign timeout_s = busy_s && (wdog_r == CNT_W'(TIMEOUT_CYC));
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and next-output logic; every output is taken from a register.
  always_comb begin
    state_s   = state_r;
    addr_s    = addr_r;
    wdata_s   = wdata_r;
    awvalid_s = awvalid_r;
    wvalid_s  = wvalid_r;
    arvalid_s = arvalid_r;
    valid_s   = 1'b0;
    data_s    = data_r;
    err_s     = err_r;
    if (timeout_s) begin
      awvalid_s = 1'b0;
      wvalid_s  = 1'b0;
      arvalid_s = 1'b0;
      data_s    = 32'h0;
      err_s     = 3'b100;
      valid_s   = 1'b1;
      state_s   = DONE;
    end else begin
      case (state_r)
        IDLE: begin
          if (a4lm_wr_cmd) begin
            addr_s    = a4lm_addr;
            wdata_s   = a4lm_wr_data;
            awvalid_s = 1'b1;
            wvalid_s  = 1'b1;
            state_s   = WR_REQ;
          end else if (a4lm_rd_cmd) begin
            addr_s    = a4lm_addr;
            arvalid_s = 1'b1;
            state_s   = RD_REQ;
          end else begin
            state_s   = IDLE;
          end
        end
        WR_REQ: begin
          // AW and W retire independently; leave only when both have.
          awvalid_s = awvalid_r && !m_axi_awready;
          wvalid_s  = wvalid_r && !m_axi_wready;
          if (!awvalid_s && !wvalid_s) begin
            state_s = WR_RESP;
          end else begin
            state_s = WR_REQ;
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid && bready_r) begin
            data_s  = 32'h0;
            err_s   = {1'b0, m_axi_bresp};
            valid_s = 1'b1;
            state_s = DONE;
          end else begin
            state_s = WR_RESP;
          end
        end
        RD_REQ: begin
          if (arvalid_r && m_axi_arready) begin
            arvalid_s = 1'b0;
            state_s   = RD_RESP;
          end else begin
            state_s   = RD_REQ;
          end
        end
        RD_RESP: begin
          if (m_axi_rvalid && rready_r) begin
            data_s  = (m_axi_rresp == 2'b00) ? m_axi_rdata : 32'h0;
            err_s   = {1'b0, m_axi_rresp};
            valid_s = 1'b1;
            state_s = DONE;
          end else begin
            state_s = RD_RESP;
          end
        end
        DONE: begin
          state_s = IDLE;
        end
        default: begin
          awvalid_s = 1'b0;
          wvalid_s  = 1'b0;
          arvalid_s = 1'b0;
          state_s   = IDLE;
        end
      endcase
    end
    bready_s = (state_s == IDLE) || (state_s == WR_RESP);
    rready_s = (state_s == IDLE) || (state_s == RD_RESP);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      addr_r    <= '0;
      wdata_r   <= 32'h0;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      arvalid_r <= 1'b0;
      bready_r  <= 1'b0;
      rready_r  <= 1'b0;
      valid_r   <= 1'b0;
      data_r    <= 32'h0;
      err_r     <= 3'b000;
    end else begin
      state_r   <= state_s;
      addr_r    <= addr_s;
      wdata_r   <= wdata_s;
      awvalid_r <= awvalid_s;
      wvalid_r  <= wvalid_s;
      arvalid_r <= arvalid_s;
      bready_r  <= bready_s;
      rready_r  <= rready_s;
      valid_r   <= valid_s;
      data_r    <= data_s;
      err_r     <= err_s;
    end
  end

  assign a4lm_valid    = valid_r;
  assign a4lm_data     = data_r;
  assign a4lm_err_code = err_r;
  assign m_axi_awaddr  = addr_r;
  assign m_axi_araddr  = addr_r;
  assign m_axi_awvalid = awvalid_r;
  assign m_axi_wdata   = wdata_r;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = wvalid_r;
  assign m_axi_bready  = bready_r;
  assign m_axi_arvalid = arvalid_r;
  assign m_axi_rready  = rready_r;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Self-checking bench for axi4_lite_master: directed table, random vectors, reset/stall corners.
module tb_axi4_lite_master;
  localparam int ADDR_W = 32;
  localparam int TO_CYC = 16;

  logic              clk, reset;
  logic [ADDR_W-1:0] a4lm_addr;
  logic [31:0]       a4lm_wr_data;
  logic              a4lm_wr_cmd, a4lm_rd_cmd;
  logic              a4lm_valid;
  logic [31:0]       a4lm_data;
  logic [2:0]        a4lm_err_code;
  logic [ADDR_W-1:0] m_axi_awaddr, m_axi_araddr;
  logic              m_axi_awvalid, m_axi_awready;
  logic [31:0]       m_axi_wdata;
  logic [3:0]        m_axi_wstrb;
  logic              m_axi_wvalid, m_axi_wready;
  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid, m_axi_bready;
  logic              m_axi_arvalid, m_axi_arready;
  logic [31:0]       m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rvalid, m_axi_rready;

  int checks = 0;
  int failures = 0;

  axi4_lite_master #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .reset(reset),
    .a4lm_addr(a4lm_addr), .a4lm_wr_data(a4lm_wr_data),
    .a4lm_wr_cmd(a4lm_wr_cmd), .a4lm_rd_cmd(a4lm_rd_cmd),
    .a4lm_valid(a4lm_valid), .a4lm_data(a4lm_data), .a4lm_err_code(a4lm_err_code),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          a_dly;
    int          w_dly;
    int          r_dly;
    logic        extra_rd;
    logic [31:0] exp_data;
    logic [2:0]  exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic rd, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic [1:0] resp, input int a_dly, input int w_dly,
                              input int r_dly, input logic extra_rd,
                              input logic [31:0] exp_data, input logic [2:0] exp_err);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.resp = resp;
    v.a_dly = a_dly; v.w_dly = w_dly; v.r_dly = r_dly; v.extra_rd = extra_rd;
    v.exp_data = exp_data; v.exp_err = exp_err;
    return v;
  endfunction

  // Reference rule: a write wins over a read; reads return data only on OKAY; err = {0, resp}.
  function automatic vec_t with_model(input vec_t v);
    vec_t r;
    r = v;
    r.exp_err  = {1'b0, v.resp};
    r.exp_data = (!v.wr && v.resp == 2'b00) ? v.rdata : 32'h0;
    return r;
  endfunction

  task automatic slave_idle();
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0;
    m_axi_bresp = 2'b00; m_axi_rresp = 2'b00; m_axi_rdata = 32'h0;
  endtask

  // Issue one command and act as an AXI slave with the vector's delays.
  task automatic run_txn(input vec_t v);
    int aw_w, w_w, ar_w, rs_w, pulses, post;
    bit aw_hs, w_hs, ar_hs, aw_done, w_done, ar_done, rsp_done, p_aw, p_w, p_ar, is_wr, finished;
    aw_w = 0; w_w = 0; ar_w = 0; rs_w = 0; pulses = 0; post = 0;
    aw_hs = 0; w_hs = 0; ar_hs = 0; aw_done = 0; w_done = 0; ar_done = 0; rsp_done = 0;
    p_aw = 0; p_w = 0; p_ar = 0; finished = 0;
    is_wr = v.wr;
    @(negedge clk);
    a4lm_addr = v.addr; a4lm_wr_data = v.wdata; a4lm_wr_cmd = v.wr; a4lm_rd_cmd = v.rd;
    @(negedge clk);
    a4lm_wr_cmd = 1'b0; a4lm_rd_cmd = 1'b0;
    a4lm_addr = $urandom; a4lm_wr_data = $urandom;
    chk("req_latency", {29'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid},
        is_wr ? 32'd6 : 32'd1);
    for (int cyc = 0; cyc < 60 && !finished; cyc++) begin
      if (cyc > 0) @(negedge clk);
      a4lm_rd_cmd = v.extra_rd && (cyc == 1);
      if (is_wr) chk("wr_no_arvalid", 32'(m_axi_arvalid), 32'd0);
      else       chk("rd_no_awvalid", 32'(m_axi_awvalid | m_axi_wvalid), 32'd0);
      if (aw_hs) chk("awvalid_drop", 32'(m_axi_awvalid), 32'd0);
      else if (p_aw) chk("awvalid_hold", 32'(m_axi_awvalid), 32'd1);
      if (w_hs) chk("wvalid_drop", 32'(m_axi_wvalid), 32'd0);
      else if (p_w) chk("wvalid_hold", 32'(m_axi_wvalid), 32'd1);
      if (ar_hs) chk("arvalid_drop", 32'(m_axi_arvalid), 32'd0);
      else if (p_ar) chk("arvalid_hold", 32'(m_axi_arvalid), 32'd1);
      if (m_axi_awvalid) chk("awaddr", m_axi_awaddr, v.addr);
      if (m_axi_wvalid) begin
        chk("wdata", m_axi_wdata, v.wdata);
        chk("wstrb", 32'(m_axi_wstrb), 32'hF);
      end
      if (m_axi_arvalid) chk("araddr", m_axi_araddr, v.addr);
      if (a4lm_valid) begin
        pulses++;
        chk("a4lm_data", a4lm_data, v.exp_data);
        chk("a4lm_err", 32'(a4lm_err_code), 32'(v.exp_err));
      end else if (pulses > 0) begin
        post++;
        chk("idle_valids", {29'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 32'd0);
        chk("idle_readies", {30'd0, m_axi_bready, m_axi_rready}, 32'd3);
        chk("data_hold", a4lm_data, v.exp_data);
        chk("err_hold", 32'(a4lm_err_code), 32'(v.exp_err));
        if (post >= 3) finished = 1;
      end
      // Responses start only after the request handshakes have retired.
      m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0;
      m_axi_bresp = v.resp; m_axi_rresp = v.resp; m_axi_rdata = v.rdata;
      if (is_wr && aw_done && w_done && !rsp_done) begin
        if (rs_w >= v.r_dly) begin
          m_axi_bvalid = 1'b1;
          if (m_axi_bready) rsp_done = 1;
        end
        rs_w++;
      end
      if (!is_wr && ar_done && !rsp_done) begin
        if (rs_w >= v.r_dly) begin
          m_axi_rvalid = 1'b1;
          if (m_axi_rready) rsp_done = 1;
        end
        rs_w++;
      end
      p_aw = m_axi_awvalid; p_w = m_axi_wvalid; p_ar = m_axi_arvalid;
      m_axi_awready = m_axi_awvalid && (aw_w >= v.a_dly);
      m_axi_wready  = m_axi_wvalid && (w_w >= v.w_dly);
      m_axi_arready = m_axi_arvalid && (ar_w >= v.a_dly);
      if (m_axi_awvalid) aw_w++;
      if (m_axi_wvalid) w_w++;
      if (m_axi_arvalid) ar_w++;
      aw_hs = m_axi_awready; w_hs = m_axi_wready; ar_hs = m_axi_arready;
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      if (ar_hs) ar_done = 1;
    end
    chk("valid_pulses", pulses, 32'd1);
    a4lm_rd_cmd = 1'b0;
    slave_idle();
  endtask

  initial begin
    vec_t v;
    int k;
    bit seen;
    reset = 1'b1;
    a4lm_addr = '0; a4lm_wr_data = 32'h0; a4lm_wr_cmd = 1'b0; a4lm_rd_cmd = 1'b0;
    slave_idle();
    #1;
    chk("rst_valids", {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                       m_axi_bready, m_axi_rready}, 32'd0);
    chk("rst_a4lm", {31'd0, a4lm_valid}, 32'd0);
    chk("rst_data", a4lm_data, 32'd0);
    chk("rst_err", 32'(a4lm_err_code), 32'd0);
    chk("rst_wstrb", 32'(m_axi_wstrb), 32'hF);
    chk("rst_awaddr", m_axi_awaddr, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_bready_rready", {30'd0, m_axi_bready, m_axi_rready}, 32'd3);

    // Stray responses in IDLE are swallowed.
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'b10; m_axi_rvalid = 1'b1; m_axi_rresp = 2'b11;
    m_axi_rdata = 32'hFFFF0000;
    @(negedge clk);
    slave_idle();
    for (int i = 0; i < 3; i++) begin
      chk("stray_no_valid", {31'd0, a4lm_valid}, 32'd0);
      chk("stray_err", 32'(a4lm_err_code), 32'd0);
      @(negedge clk);
    end

    tbl.push_back(mk(1'b1, 1'b0, 32'h10, 32'hA5A5A5A5, 32'h0, 2'b00, 0, 0, 0, 1'b0, 32'h0, 3'b000));
    tbl.push_back(mk(1'b1, 1'b0, 32'h14, 32'h5A5A5A5A, 32'h0, 2'b00, 3, 0, 1, 1'b0, 32'h0, 3'b000));
    tbl.push_back(mk(1'b0, 1'b1, 32'h20, 32'h0, 32'hDEADBEEF, 2'b00, 0, 0, 0, 1'b0, 32'hDEADBEEF, 3'b000));
    tbl.push_back(mk(1'b0, 1'b1, 32'h24, 32'h0, 32'hDEADBEEF, 2'b10, 1, 0, 2, 1'b0, 32'h0, 3'b010));
    tbl.push_back(mk(1'b1, 1'b1, 32'h30, 32'h0BADF00D, 32'h0, 2'b00, 1, 2, 0, 1'b0, 32'h0, 3'b000));
    tbl.push_back(mk(1'b0, 1'b1, 32'h34, 32'h0, 32'h13579BDF, 2'b00, 2, 0, 2, 1'b1, 32'h13579BDF, 3'b000));
    tbl.push_back(mk(1'b1, 1'b0, 32'h38, 32'hCAFEF00D, 32'h0, 2'b11, 0, 2, 1, 1'b1, 32'h0, 3'b011));
    tbl.push_back(mk(1'b0, 1'b1, 32'h3C, 32'h0, 32'h89ABCDEF, 2'b01, 0, 0, 1, 1'b0, 32'h0, 3'b001));
    foreach (tbl[i]) run_txn(tbl[i]);

    for (int i = 0; i < 30; i++) begin
      v.wr = 1'($urandom_range(0, 1));
      v.rd = v.wr ? 1'($urandom_range(0, 1)) : 1'b1;
      v.addr = $urandom & 32'hFFFF_FFFC;
      v.wdata = $urandom;
      v.rdata = $urandom;
      v.resp = 2'($urandom_range(0, 3));
      v.a_dly = $urandom_range(0, 3);
      v.w_dly = $urandom_range(0, 3);
      v.r_dly = $urandom_range(0, 3);
      v.extra_rd = ($urandom_range(0, 3) == 0);
      v.exp_data = 32'h0;
      v.exp_err = 3'b000;
      run_txn(with_model(v));
    end

    // Read with the slave never accepting the address.
    @(negedge clk);
    a4lm_addr = 32'h80; a4lm_rd_cmd = 1'b1;
    @(negedge clk);
    a4lm_rd_cmd = 1'b0;
    chk("stall_arvalid_rise", {31'd0, m_axi_arvalid}, 32'd1);
    k = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      k++;
      if (a4lm_valid) seen = 1;
    end
`ifdef A4LM_TIMEOUT_EN
    chk("timeout_latency", k, 32'd17);
    chk("timeout_err", 32'(a4lm_err_code), 32'd4);
    chk("timeout_data", a4lm_data, 32'd0);
    chk("timeout_arvalid", {31'd0, m_axi_arvalid}, 32'd0);
    @(negedge clk);
    chk("timeout_pulse_once", {31'd0, a4lm_valid}, 32'd0);
`else
    chk("stall_no_valid", {31'd0, seen}, 32'd0);
    chk("stall_arvalid_held", {31'd0, m_axi_arvalid}, 32'd1);
    chk("stall_err2", {31'd0, a4lm_err_code[2]}, 32'd0);
    reset = 1'b1;
    #1;
    chk("stall_reset_arvalid", {31'd0, m_axi_arvalid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
`endif

    // Reset while waiting for the write response.
    @(negedge clk);
    a4lm_addr = 32'h40; a4lm_wr_data = 32'h12345678; a4lm_wr_cmd = 1'b1;
    @(negedge clk);
    a4lm_wr_cmd = 1'b0;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    @(negedge clk);
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    chk("wresp_valids", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'd0);
    chk("wresp_bready", {31'd0, m_axi_bready}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_valids", {26'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                          m_axi_bready, m_axi_rready, a4lm_valid}, 32'd0);
    chk("midrst_wstrb", 32'(m_axi_wstrb), 32'hF);
    chk("midrst_err", 32'(a4lm_err_code), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_txn(mk(1'b1, 1'b0, 32'h44, 32'h87654321, 32'h0, 2'b00, 1, 1, 1, 1'b0, 32'h0, 3'b000));
    run_txn(mk(1'b0, 1'b1, 32'h48, 32'h0, 32'h0F0F0F0F, 2'b00, 0, 0, 0, 1'b0, 32'h0F0F0F0F, 3'b000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
